// File: rtl/serial_subtractor.sv
// Bit-serial add/subtract unit, LSB first, one bit per clock.
// Hands result, sign bits and flags to a downstream less-than stage.
module serial_subtractor #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             r_msb,
  output logic             a_msb,
  output logic             b_msb,
  output logic             ovf,
  output logic             carry,
  output logic             zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state;
  state_t state_nx;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res;
  logic [CW-1:0]    cnt;
  logic             sub_q;
  logic             c_q;
  logic             a_msb_q;
  logic             b_msb_q;
  logic             ovf_q;
  logic             carry_q;

  logic accept;
  logic last;
  logic bi;
  logic sum;
  logic c_nx;

  assign accept = (state == IDLE) && in_valid;
  assign last   = (state == SHIFT) && (cnt == CW'(WIDTH - 1));
  assign bi     = b_sh[0] ^ sub_q;
  assign sum    = a_sh[0] ^ bi ^ c_q;
  assign c_nx   = (a_sh[0] & bi) | (a_sh[0] & c_q) | (bi & c_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (in_valid) state_nx = SHIFT;
      SHIFT:   if (last) state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      IDLE:    in_ready = 1'b1;
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh    <= '0;
      b_sh    <= '0;
      res     <= '0;
      cnt     <= '0;
      sub_q   <= 1'b0;
      c_q     <= 1'b0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf_q   <= 1'b0;
      carry_q <= 1'b0;
    end else if (accept) begin
      a_sh    <= a;
      b_sh    <= b;
      sub_q   <= sub;
      c_q     <= sub;
      cnt     <= '0;
      a_msb_q <= a[WIDTH-1];
      b_msb_q <= b[WIDTH-1];
    end else if (state == SHIFT) begin
      a_sh <= a_sh >> 1;
      b_sh <= b_sh >> 1;
      c_q  <= c_nx;
      res  <= {sum, res[WIDTH-1:1]};
      cnt  <= cnt + CW'(1);
      // c_q is the carry into the top bit on this edge
      if (last) begin
        ovf_q   <= c_q ^ c_nx;
        carry_q <= c_nx;
      end
    end
  end

  assign result = res;
  assign r_msb  = res[WIDTH-1];
  assign a_msb  = a_msb_q;
  assign b_msb  = b_msb_q;
  assign ovf    = ovf_q;
  assign carry  = carry_q;
  assign zero   = (res == '0);

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter: WIDTH, default 32, operand width in bits; legal values 2..64.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  operand word offered.
REQ-005 in_ready  output  1  block can accept an operand word.
REQ-006 sub  input  1  1 = A-B, 0 = A+B; sampled at accept.
REQ-007 a  input  WIDTH  operand A; sampled at accept.
REQ-008 b  input  WIDTH  operand B; sampled at accept.
REQ-009 out_valid  output  1  result fields valid.
REQ-010 out_ready  input  1  downstream less-than stage consumes the result.
REQ-011 result  output  WIDTH  A+B or A-B, modulo 2^WIDTH.
REQ-012 r_msb  output  1  result[WIDTH-1]; R input of the downstream less-than stage.
REQ-013 a_msb  output  1  A[WIDTH-1] of the captured operand.
REQ-014 b_msb  output  1  B[WIDTH-1] of the captured operand (unmodified, pre-inversion).
REQ-015 ovf  output  1  signed overflow; O input of the downstream less-than stage.
REQ-016 carry  output  1  carry out of bit WIDTH-1.
REQ-017 zero  output  1  1 when result == 0.

Function
REQ-018 State machine: IDLE, SHIFT, DONE.
REQ-019 in_ready SHALL be 1 exactly when state == IDLE.
REQ-020 Accept: in IDLE with in_valid=1 at an edge, capture a, b and sub, load carry register with sub, clear bit counter, go to SHIFT.
REQ-021 in_valid is ignored in SHIFT and DONE; operands are not re-sampled.
REQ-022 SHIFT: one bit per edge, LSB first; sum bit = a_i XOR (b_i XOR sub) XOR c; carry updated by full-adder majority; sum bit shifted into result from the MSB end.
REQ-023 Counter: ceil(log2(WIDTH)) bits; SHIFT lasts exactly WIDTH edges; on the edge that processes bit WIDTH-1, go to DONE.
REQ-024 ovf = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1; this carry pair is recorded on the final SHIFT edge.
REQ-025 Latency: out_valid rises WIDTH edges after the accept edge.
REQ-026 DONE: out_valid=1; result, r_msb, a_msb, b_msb, ovf, carry and zero stay stable until the handshake completes.
REQ-027 Handshake completes on an edge with out_valid=1 and out_ready=1; state goes to IDLE.
REQ-028 No new accept occurs on the handshake edge; minimum initiation interval is WIDTH+2 cycles.
REQ-029 out_ready held low in DONE stalls indefinitely with all outputs unchanged.
REQ-030 out_valid SHALL be 0 in IDLE and SHIFT; result fields there are don't-care, except as fixed by reset.
REQ-031 Add with sub=0: ovf and carry follow the same rules; b_msb still reports unmodified B.

Reset
REQ-032 rst_n low: immediately state=IDLE, in_ready=1, out_valid=0, and result, r_msb, a_msb, b_msb, ovf, carry, counter cleared to 0; zero=1.
REQ-033 Reset asserted mid-SHIFT or in DONE aborts the operation; no out_valid follows for the aborted word.
REQ-034 The first accept is possible on the first rising edge after rst_n deasserts.

Verification (WIDTH=8)
REQ-035 sub=1, a=0x05, b=0x03 -> after 8 edges: out_valid=1, result=0x02, r_msb=0, ovf=0, carry=1, zero=0.
REQ-036 sub=1, a=0x80, b=0x01 -> result=0x7F, a_msb=1, b_msb=0, r_msb=0, ovf=1.
REQ-037 sub=0, a=0x7F, b=0x01 -> result=0x80, ovf=1, carry=0; sub=1, a=b=0x33 -> result=0x00, zero=1, carry=1.
REQ-038 out_ready=0 for 5 cycles in DONE -> outputs constant and in_ready=0 throughout; in_valid pulses during SHIFT are ignored, and result still matches the first operands.
REQ-039 rst_n pulsed low during edge 4 of SHIFT -> out_valid never rises for that word; all outputs match REQ-032; a fresh accept after reset yields a correct result with a latency of 8.
